// File: rtl/arm_pkg.sv
// Shared types and constants for the instruction-fetch path.
package arm_pkg;

  localparam int unsigned WORD_W = 32;

  // ARM "always" condition field, useful when decoding fetched words.
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction memory, decode handshake, redirect and status.
interface fetch_ctrl_if
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) ();

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              en;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              dec_ready;
  logic              inst_valid;
  logic [WORD_W-1:0] inst_out;
  logic [WORD_W-1:0] inst_pc4;
  logic              br_taken;
  logic [WORD_W-1:0] br_target;
  logic              fault;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    input  en, mem_rdata, dec_ready, br_taken, br_target,
    output mem_addr, inst_valid, inst_out, inst_pc4, fault, occupancy
  );

  modport slave (
    output en, mem_rdata, dec_ready, br_taken, br_target,
    input  mem_addr, inst_valid, inst_out, inst_pc4, fault, occupancy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push/pop, storage resets to zero.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wr_data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    do_push  = push_i & ~flush_i & (~full_o | pop_i);
    do_pop   = pop_i & ~flush_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and fault flag, feeds decode through a prefetch FIFO.
module fetch_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      MEM_WORDS = 51
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              in_range, deq, fetch;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      wr_entry, head;

  // Fetch/redirect decision; a branch overrides every FIFO update and clears fault.
  always_comb begin
    in_range = ((pc_q >> 2) < WORD_W'(MEM_WORDS));
    deq      = ~fifo_empty & bus.dec_ready;
    fetch    = bus.en & ~fault_q & ~bus.br_taken & in_range & (~fifo_full | deq);
    wr_entry = '{instr: bus.mem_rdata, pc4: pc_q + WORD_W'(4)};
    pc_d     = pc_q;
    fault_d  = fault_q;
    if (bus.br_taken) begin
      pc_d    = {bus.br_target[WORD_W-1:2], 2'b00};
      fault_d = 1'b0;
    end else begin
      if (fetch)                 pc_d    = pc_q + WORD_W'(4);
      if (bus.en && !in_range)   fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (fetch),
    .pop_i     (deq),
    .flush_i   (bus.br_taken),
    .wr_data_i (wr_entry),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .head_o    (head)
  );

  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_out   = head.instr;
  assign bus.inst_pc4   = head.pc4;
  assign bus.fault      = fault_q;
  assign bus.occupancy  = fifo_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised bench for fetch_ctrl: queue-based reference model feeds a scoreboard checked by a monitor.
module tb_fetch_ctrl;
  import arm_pkg::*;

  localparam int unsigned DEPTH     = 2;
  localparam int unsigned MEM_WORDS = 51;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef struct {
    logic        valid;
    int          occ;
    logic [31:0] addr;
    logic        fault;
  } exp_stat_t;

  logic clk = 1'b0;
  logic rst;

  fetch_ctrl_if #(.DEPTH(DEPTH)) bus ();

  fetch_ctrl #(
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [MEM_WORDS];

  assign bus.mem_rdata = (bus.mem_addr[31:2] < 30'(MEM_WORDS)) ? rom[bus.mem_addr[7:2]] : 32'hDEAD_BEEF;

  int pass_cnt  = 0;
  int check_cnt = 0;

  fetch_entry_t mq[$];     // model FIFO contents, head first
  fetch_entry_t exp_q[$];  // entries decode is expected to consume, in order
  exp_stat_t    stat_q[$]; // expected per-cycle status

  logic [31:0] m_pc    = RESET_PC;
  logic        m_fault = 1'b0;
  logic        p_rst = 1'b1, p_en = 1'b0, p_dr = 1'b0, p_bt = 1'b0;
  logic [31:0] p_tgt = '0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w < 32'(MEM_WORDS)) ? rom[w[5:0]] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Effect of one clock edge given the inputs held during the cycle before it.
  function automatic void model_edge();
    bit deq, inr, fetch;
    if (p_rst) return;
    deq = (mq.size() > 0) && p_dr;
    inr = (m_pc >> 2) < 32'(MEM_WORDS);
    if (p_bt) begin
      mq.delete();
      m_pc    = {p_tgt[31:2], 2'b00};
      m_fault = 1'b0;
      return;
    end
    if (deq) void'(mq.pop_front());
    fetch = p_en && !m_fault && inr && (mq.size() < int'(DEPTH));
    if (fetch) begin
      mq.push_back('{instr: rom_word(m_pc), pc4: m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
    if (p_en && !inr) m_fault = 1'b1;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic dr, input logic bt,
                       input logic [31:0] tgt);
    exp_stat_t s;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; bus.en = e; bus.dec_ready = dr; bus.br_taken = bt; bus.br_target = tgt;
    p_rst = r; p_en = e; p_dr = dr; p_bt = bt; p_tgt = tgt;
    if (r) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end
    s.valid = (mq.size() > 0);
    s.occ   = mq.size();
    s.addr  = m_pc;
    s.fault = m_fault;
    stat_q.push_back(s);
    if (!r && dr && mq.size() > 0) exp_q.push_back(mq[0]);
  endtask

  task automatic run(input int n, input logic e, input logic dr);
    for (int i = 0; i < n; i++) cycle(1'b0, e, dr, 1'b0, 32'h0);
  endtask

  // Monitor: status every cycle, instruction data whenever decode takes the head.
  always @(negedge clk) begin
    exp_stat_t    s;
    fetch_entry_t e;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("inst_valid", 32'(bus.inst_valid), 32'(s.valid));
      check("occupancy", 32'(bus.occupancy), 32'(s.occ));
      check("mem_addr", bus.mem_addr, s.addr);
      check("fault", 32'(bus.fault), 32'(s.fault));
    end
    if (bus.inst_valid === 1'b1 && bus.dec_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_deq: got pc4 %h expected no dequeue (t=%0t)", bus.inst_pc4, $time);
      end else begin
        e = exp_q.pop_front();
        check("inst_out", bus.inst_out, e.instr);
        check("inst_pc4", bus.inst_pc4, e.pc4);
        check("cond_field", 32'(bus.inst_out[31:28]), 32'(e.instr[31:28]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, e, dr, bt;
    logic [31:0] t;
    rst = 1'b1; bus.en = 1'b0; bus.dec_ready = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    rom[0] = 32'hE3A00014;
    rom[1] = 32'hE3A01A01;
    for (int i = 2; i < int'(MEM_WORDS); i++) rom[i] = {COND_AL, 28'(i * 32'h0012_3457)};

    // Streaming from reset with decode always ready.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(8, 1'b1, 1'b1);

    // Back-pressure from reset, then release.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(4, 1'b1, 1'b0);
    run(4, 1'b1, 1'b1);

    // Branch to an unaligned target while the FIFO is full.
    run(3, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0027);
    run(3, 1'b1, 1'b1);

    // Branch onto the last word: one fetch, then fault; redirect back to 0 recovers.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00C8);
    run(5, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
    run(4, 1'b1, 1'b1);

    // Reset mid-stream with a full FIFO.
    run(4, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    run(3, 1'b1, 1'b1);

    // Enable dropped with one entry queued, then resumed.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run(1, 1'b1, 1'b0);
    run(3, 1'b0, 1'b1);
    run(4, 1'b1, 1'b1);

    // Branch and dequeue in the same cycle.
    run(2, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    run(3, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(99) < 2);
      e  = ($urandom_range(9) != 0);
      dr = ($urandom_range(9) < 6);
      bt = ($urandom_range(99) < 5);
      t  = 32'($urandom_range(MEM_WORDS * 4 + 12));
      cycle(r, e, dr, bt, t);
    end

    run(2, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("status_drained", 32'(stat_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
